// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display.
// Drives one BCD nibble and one digit enable per slot from a double-buffered value.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 1000,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start,
  output logic                    pending,
  output logic                    err
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [SW-1:0]           slot;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    run;
  logic                    boundary;

  logic [NUM_DIGITS-1:0]   invalid;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_above;
  logic [3:0]              nib;
  logic                    cur_blank;

  // run holds the scan at slot 0 / presc 0 for one edge after reset release,
  // so the first registered cycle carries frame_start like any other frame.
  assign boundary = run && (presc == PRESC_LAST) && (slot == SLOT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      slot        <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      run         <= 1'b0;
    end else begin
      run         <= 1'b1;
      frame_start <= !run || boundary;

      if (run) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          slot  <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end

      if (boundary) begin
        if (load) begin
          active  <= digits_in;
          pending <= 1'b0;
        end else if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (load) begin
        shadow  <= digits_in;
        pending <= 1'b1;
      end
    end
  end

  // Scan digits from the most significant down so zero_above means
  // "this nibble and every nibble above it are zero".
  // NOTE: every variable written here gets a default first, so no path can
  // leave it holding a previous value and infer a latch.
  always_comb begin
    invalid    = '0;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (active[4*i +: 4] == 4'd0);
      invalid[i]  = active[4*i +: 4] > 4'd9;
      lz_blank[i] = blank_lz && (i != 0) && zero_above;
    end
  end

  always_comb begin
    nib       = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SW'(i)) begin
        nib       = active[4*i +: 4];
        cur_blank = invalid[i] || lz_blank[i];
      end
    end
  end

  assign bcd      = cur_blank ? 4'd0 : nib;
  assign digit_en = (!run || (presc < DEAD_LIM) || cur_blank)
                    ? '0 : (NUM_DIGITS'(1) << slot);
  assign err      = |invalid;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: a time-based reference model pushes
// the expected outputs for every cycle, a monitor pops and compares them.
module tb_bcd_display_scanner;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int DC    = 1;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    bcd;
  logic [ND-1:0] digit_en;
  logic          frame_start;
  logic          pending;
  logic          err;

  bcd_display_scanner #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .digit_en   (digit_en),
    .frame_start(frame_start),
    .pending    (pending),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    bcd;
    logic [ND-1:0] den;
    logic          fs;
    logic          pend;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: cyc counts clock edges since reset release; the scan
  // position is plain arithmetic on that count (one idle edge after release).
  int          cyc;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pend;

  function automatic int m_presc();
    return (cyc == 0) ? 0 : (cyc - 1) % PS;
  endfunction

  function automatic int m_slot();
    return (cyc == 0) ? 0 : ((cyc - 1) / PS) % ND;
  endfunction

  task automatic model_reset();
    cyc      = 0;
    m_active = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int   s, p, nib, upper;
    bit   blanked;
    e = '0;
    if (rst_n) begin
      s       = m_slot();
      p       = m_presc();
      upper   = int'(m_active) >> (4 * s);
      nib     = upper & 15;
      blanked = (nib > 9) || (blank_lz && s != 0 && upper == 0);
      e.bcd   = blanked ? 4'd0 : 4'(nib);
      e.den   = (cyc == 0 || p < DC || blanked) ? '0 : ND'(1 << s);
      e.fs    = (cyc >= 1) && (p == 0) && (s == 0);
      e.pend  = m_pend;
      for (int i = 0; i < ND; i++)
        if (((int'(m_active) >> (4 * i)) & 15) > 9) e.err = 1'b1;
    end
    return e;
  endfunction

  initial begin
    logic        ld;
    logic [15:0] din;
    bit          bnd;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) begin
        ld  = load;
        din = digits_in;
        bnd = (cyc >= 1) && ((cyc - 1) % FRAME == FRAME - 1);
        if (ld && bnd) begin
          m_active = din;
          m_pend   = 1'b0;
        end else if (ld) begin
          m_shadow = din;
          m_pend   = 1'b1;
        end else if (bnd && m_pend) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
        cyc++;
      end else begin
        model_reset();
      end
      #3;
      if (!rst_n) model_reset();
      sb_q.push_back(model_expect());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("bcd",         32'(bcd),         32'(e.bcd));
        check("digit_en",    32'(digit_en),    32'(e.den));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("pending",     32'(pending),     32'(e.pend));
        check("err",         32'(err),         32'(e.err));
      end
    end
  end

  // Driver stays in the phase 2 time units after each rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_at(input int s, input int p);
    int n = 0;
    while (!(cyc >= 1 && m_slot() == s && m_presc() == p)) begin
      tick();
      n++;
      if (n > 4 * FRAME) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_at timeout: slot %0d presc %0d not reached", s, p);
        return;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    digits_in = v;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    int          lead;
    v = '0;
    for (int i = 0; i < ND; i++)
      v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    lead = $urandom_range(0, ND);
    for (int i = ND - lead; i < ND; i++) v[4*i +: 4] = 4'd0;
    return v;
  endfunction

  initial begin
    tick(3);
    rst_n = 1'b1;

    // Load mid-frame, committed at the next boundary.
    wait_at(1, 0);
    do_load(16'h1234);
    tick(2 * FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0042);
    tick(2 * FRAME);
    do_load(16'h0000);
    tick(2 * FRAME);
    blank_lz = 1'b0;
    tick(FRAME);

    // Two loads in one frame: latest wins, old value held until the boundary.
    wait_at(1, 1);
    do_load(16'h1111);
    wait_at(3, 1);
    do_load(16'h2222);
    tick(2 * FRAME);

    // Load exactly on the boundary edge commits directly.
    wait_at(3, 3);
    do_load(16'h5678);
    tick(FRAME);

    // Invalid nibble detection and recovery.
    do_load(16'h12A4);
    tick(2 * FRAME);
    do_load(16'h1294);
    tick(2 * FRAME);

    // Randomized loads, blanking mode and occasional back-to-back loads.
    for (int k = 0; k < 40; k++) begin
      blank_lz = 1'($urandom_range(0, 1));
      tick($urandom_range(0, FRAME + 4));
      do_load(rand_val());
      if ($urandom_range(0, 3) == 0) do_load(rand_val());
    end
    tick(2 * FRAME);

    // Asynchronous reset mid-slot, then restart.
    blank_lz = 1'b0;
    do_load(16'h9876);
    tick(FRAME);
    wait_at(2, 2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2 * FRAME);
    do_load(16'h0305);
    tick(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Time-multiplexed scan controller for an NUM_DIGITS-digit common-cathode 7-segment display.
- Sits directly upstream of the BCD-to-7-segment decoder: presents one BCD nibble per scan slot on `bcd` (wired to the decoder's `bcd` input) and drives the matching one-hot digit enable.
- Holds a double-buffered display value so that a new value is only applied at a frame boundary (no tearing).
- Provides leading-zero blanking, anti-ghosting dead time, and invalid-digit detection.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8); digit 0 is least significant (rightmost).
- PRESCALE, 1000, clock cycles per scan slot (>= 2).
- DEAD_CYCLES, 1, cycles at the start of each slot with all digit enables off (0 <= DEAD_CYCLES < PRESCALE).

Ports:
- clk  input  1  system clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; captures digits_in.
- digits_in  input  4*NUM_DIGITS  packed BCD value; nibble i = digit i.
- blank_lz  input  1  1 = leading-zero blanking enabled (sampled combinationally every cycle).
- bcd  output  4  BCD nibble for the current slot; feeds the decoder.
- digit_en  output  NUM_DIGITS  one-hot active-high digit enable; all zero when blanked or in dead time.
- frame_start  output  1  one-cycle pulse on the first cycle of slot 0.
- pending  output  1  a loaded value is waiting for the next frame boundary.
- err  output  1  committed value contains a nibble > 9.

Behaviour:
- Reset (async assert, sync release): presc=0, slot=0, active=0, shadow=0, pending=0, frame_start=0.
  - While reset is held: digit_en=0, bcd=0, err=0.
  - After release, scanning starts at slot 0 with presc=0.
- Prescaler: presc counts 0..PRESCALE-1 and wraps to 0.
  - On the wrap, slot advances by 1, wrapping NUM_DIGITS-1 -> 0.
  - The wrap from NUM_DIGITS-1 to 0 is the frame boundary.
- frame_start is registered: it is 1 exactly in the cycle where slot=0 and presc=0, including the first cycle after reset release.
- Load handling:
  - load=1 not on a boundary edge: shadow <= digits_in, pending <= 1. A later load before the boundary overwrites shadow (latest wins).
  - On the boundary edge: if load=1, active <= digits_in and pending <= 0. Else if pending=1, active <= shadow and pending <= 0. Otherwise active is unchanged.
  - Consequence: a load on the boundary edge commits directly and pending never rises.
- Outputs are combinational from registered state only; there is no extra pipeline stage.
  - nib = active[4*slot +: 4].
  - digit i is invalid when its nibble > 9.
  - digit i is leading-zero blanked when blank_lz=1, i != 0, and every nibble j >= i equals 0. Digit 0 is never leading-zero blanked.
  - blanked = invalid OR leading-zero blanked.
  - bcd = blanked ? 0 : nib.
  - digit_en = (presc < DEAD_CYCLES OR blanked) ? 0 : (1 << slot).
  - err = OR over all digits of (nibble > 9), evaluated on active (not shadow).
- Invalid nibbles 10..15 never reach the decoder.
- Reset asserted mid-frame immediately forces all outputs to their reset values and discards both shadow and active.
- Widths: presc uses $clog2(PRESCALE) bits; slot uses $clog2(NUM_DIGITS) bits, with a minimum of 1.

Test Plan:
Common settings unless stated otherwise: NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1, blank_lz=0.
1. Release reset, load digits_in=16'h1234 during slot 1 -> pending=1 until the boundary; then frame_start=1 and the next frame shows:
   - slot0: bcd=4, digit_en=0000 for 1 cycle then 0001 for 3 cycles;
   - slot1: bcd=3, digit_en=0010;
   - slot2: bcd=2, digit_en=0100;
   - slot3: bcd=1, digit_en=1000;
   - pending=0.
2. Active=16'h0042, blank_lz=1 -> slots 3 and 2 have digit_en=0000 and bcd=0; slots 1 and 0 show 4 and 2. With active=16'h0000 -> only slot 0 is enabled, showing bcd=0. With blank_lz=0 -> all four slots are enabled.
3. Load 16'h1111 in slot 1, then 16'h2222 in slot 3 of the same frame -> the old value is shown through the end of the frame; the next frame shows 2 on all digits.
4. Load 16'h5678 exactly on the boundary edge (slot 3, presc=3) -> pending stays 0 and the very next cycle shows slot0 bcd=8.
5. Load 16'h12A4 -> err=1; slot 1 has digit_en=0000 and bcd=0, other slots show normally. Loading 16'h1294 next -> err=0 after that boundary.
6. Assert rst_n=0 in slot 2, presc=2 (asynchronous, mid-cycle) -> digit_en=0, bcd=0, pending=0, err=0 within the same cycle. After release: frame_start=1, slot 0, active=0, bcd=0, with digit_en=0001 from the second cycle.
